// File: rtl/mesi_pkg.sv
// mesi_pkg: shared encodings and transition helpers for the MESI snoopy-bus controller.
// Contents: MESI state codes, bus message codes, controller FSM encoding,
//           emitter/receiver transition functions returning next state plus writeback flag.
package mesi_pkg;

    localparam int unsigned STATE_W = 2;
    localparam int unsigned MSG_W   = 2;
    localparam int unsigned FSM_W   = 3;

    // MESI state encoding
    localparam logic [STATE_W-1:0] MESI_I = 2'd0;
    localparam logic [STATE_W-1:0] MESI_S = 2'd1;
    localparam logic [STATE_W-1:0] MESI_E = 2'd2;
    localparam logic [STATE_W-1:0] MESI_M = 2'd3;

    // Bus message encoding
    localparam logic [MSG_W-1:0] MSG_NONE       = 2'd0;
    localparam logic [MSG_W-1:0] MSG_READ_MISS  = 2'd1;
    localparam logic [MSG_W-1:0] MSG_WRITE_MISS = 2'd2;
    localparam logic [MSG_W-1:0] MSG_INVALIDATE = 2'd3;

    // Controller FSM encoding
    localparam logic [FSM_W-1:0] FSM_IDLE   = 3'd0;
    localparam logic [FSM_W-1:0] FSM_SNOOP  = 3'd1;
    localparam logic [FSM_W-1:0] FSM_WB     = 3'd2;
    localparam logic [FSM_W-1:0] FSM_MEM    = 3'd3;
    localparam logic [FSM_W-1:0] FSM_UPDATE = 3'd4;

    typedef struct packed {
        logic [STATE_W-1:0] nxt;
        logic               wb;
    } trans_t;

    // Bus message the requester must broadcast for its state and op (0 read, 1 write)
    function automatic logic [MSG_W-1:0] emitter_msg(input logic [STATE_W-1:0] st, input logic op);
        logic [MSG_W-1:0] msg;
        msg = MSG_NONE;
        if (!op) begin
            if (st == MESI_I) msg = MSG_READ_MISS;
        end else begin
            if (st == MESI_I)      msg = MSG_WRITE_MISS;
            else if (st == MESI_S) msg = MSG_INVALIDATE;
        end
        return msg;
    endfunction

    // Requester next state; a read miss returns S, the caller upgrades it to E when no sharers exist
    function automatic trans_t emitter_next(input logic [STATE_W-1:0] st, input logic op);
        trans_t t;
        t.wb  = 1'b0;
        t.nxt = st;
        if (op)                  t.nxt = MESI_M;
        else if (st == MESI_I)   t.nxt = MESI_S;
        return t;
    endfunction

    // Snooping cache next state for an observed bus message
    function automatic trans_t receiver_next(input logic [STATE_W-1:0] st, input logic [MSG_W-1:0] msg);
        trans_t t;
        t.wb  = 1'b0;
        t.nxt = st;
        case (msg)
            MSG_READ_MISS: begin
                if (st == MESI_M) begin
                    t.nxt = MESI_S;
                    t.wb  = 1'b1;
                end else if (st == MESI_E) begin
                    t.nxt = MESI_S;
                end
            end
            MSG_WRITE_MISS: begin
                t.nxt = MESI_I;
                t.wb  = (st == MESI_M);
            end
            // M/E cannot coexist with a sharer; drop them silently if they ever appear
            MSG_INVALIDATE: t.nxt = MESI_I;
            default: t.nxt = st;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, scanning from ptr+1 with wraparound.
// Ports: req (request vector), ptr (last winner), grant_c (one-hot winner), index_c (winner index).
module rr_arbiter #(
    parameter int unsigned NPROC = 3,
    parameter int unsigned PTR_W = 2
) (
    input  logic [NPROC-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NPROC-1:0] grant_c,
    output logic [PTR_W-1:0] index_c
);

    logic found;
    int   j;

    // First requester after the previous winner wins
    always_comb begin
        grant_c = '0;
        index_c = '0;
        found   = 1'b0;
        j       = 0;
        for (int k = 1; k <= int'(NPROC); k++) begin
            j = (int'(ptr) + k) % int'(NPROC);
            if (!found && req[j]) begin
                found      = 1'b1;
                grant_c[j] = 1'b1;
                index_c    = PTR_W'(j);
            end
        end
    end

endmodule

// File: rtl/mesi_bus_ctrl.sv
// mesi_bus_ctrl: snoopy-bus MESI controller for one tracked block shared by NPROC caches.
// Ports: clock/reset (async active-high); req/op per cache; grant (one-hot, held per
//        transaction); done pulse; bus_valid/bus_msg broadcast; wb_req/wb_src writeback;
//        mem_req fetch; mem_ack completes either; state_out packs 2 bits of MESI state per cache.
module mesi_bus_ctrl
    import mesi_pkg::*;
#(
    parameter int unsigned NPROC = 3,
    parameter int unsigned PTR_W = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NPROC-1:0]     req,
    input  logic [NPROC-1:0]     op,
    output logic [NPROC-1:0]     grant,
    output logic                 done,
    output logic                 bus_valid,
    output logic [MSG_W-1:0]     bus_msg,
    output logic                 wb_req,
    output logic [PTR_W-1:0]     wb_src,
    output logic                 mem_req,
    input  logic                 mem_ack,
    output logic [2*NPROC-1:0]   state_out
);

    logic [FSM_W-1:0]     fsm, fsm_d;
    logic [PTR_W-1:0]     ptr, ptr_d;
    logic [PTR_W-1:0]     idx, idx_d;
    logic                 op_r, op_r_d;
    logic [STATE_W-1:0]   new_state, new_state_d;
    logic                 miss, miss_d;
    logic [NPROC-1:0]     grant_d;
    logic                 done_d, bus_valid_d, wb_req_d, mem_req_d;
    logic [MSG_W-1:0]     bus_msg_d;
    logic [PTR_W-1:0]     wb_src_d;
    logic [2*NPROC-1:0]   states_d;

    logic [NPROC-1:0]     arb_grant_c;
    logic [PTR_W-1:0]     arb_index_c;

    logic [STATE_W-1:0]   cur;
    logic [MSG_W-1:0]     msg;
    trans_t               emit, rcv;
    logic                 wb_any, others_inv;

    rr_arbiter #(.NPROC(NPROC), .PTR_W(PTR_W)) u_arb (
        .req     (req),
        .ptr     (ptr),
        .grant_c (arb_grant_c),
        .index_c (arb_index_c)
    );

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fsm       <= FSM_IDLE;
            ptr       <= PTR_W'(NPROC - 1);
            idx       <= '0;
            op_r      <= 1'b0;
            new_state <= MESI_I;
            miss      <= 1'b0;
            grant     <= '0;
            done      <= 1'b0;
            bus_valid <= 1'b0;
            bus_msg   <= MSG_NONE;
            wb_req    <= 1'b0;
            wb_src    <= '0;
            mem_req   <= 1'b0;
            state_out <= '0;
        end else begin
            fsm       <= fsm_d;
            ptr       <= ptr_d;
            idx       <= idx_d;
            op_r      <= op_r_d;
            new_state <= new_state_d;
            miss      <= miss_d;
            grant     <= grant_d;
            done      <= done_d;
            bus_valid <= bus_valid_d;
            bus_msg   <= bus_msg_d;
            wb_req    <= wb_req_d;
            wb_src    <= wb_src_d;
            mem_req   <= mem_req_d;
            state_out <= states_d;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        fsm_d       = fsm;
        ptr_d       = ptr;
        idx_d       = idx;
        op_r_d      = op_r;
        new_state_d = new_state;
        miss_d      = miss;
        grant_d     = grant;
        done_d      = 1'b0;
        bus_valid_d = 1'b0;
        bus_msg_d   = MSG_NONE;
        wb_req_d    = wb_req;
        wb_src_d    = wb_src;
        mem_req_d   = mem_req;
        states_d    = state_out;
        cur         = MESI_I;
        msg         = MSG_NONE;
        emit        = '0;
        rcv         = '0;
        wb_any      = 1'b0;
        others_inv  = 1'b1;

        case (fsm)
            FSM_IDLE: begin
                grant_d = '0;
                if (|req) begin
                    grant_d = arb_grant_c;
                    idx_d   = arb_index_c;
                    ptr_d   = arb_index_c;
                    op_r_d  = |(op & arb_grant_c);
                    fsm_d   = FSM_SNOOP;
                end
            end

            FSM_SNOOP: begin
                // Requester state, and whether every other cache was I before the snoop
                for (int i = 0; i < int'(NPROC); i++) begin
                    if (PTR_W'(i) == idx)
                        cur = state_out[2*i +: 2];
                    else if (state_out[2*i +: 2] != MESI_I)
                        others_inv = 1'b0;
                end
                msg    = emitter_msg(cur, op_r);
                emit   = emitter_next(cur, op_r);
                wb_any = emit.wb;
                for (int i = 0; i < int'(NPROC); i++) begin
                    if (PTR_W'(i) != idx) begin
                        rcv = receiver_next(state_out[2*i +: 2], msg);
                        states_d[2*i +: 2] = rcv.nxt;
                        if (rcv.wb) begin
                            wb_any   = 1'b1;
                            wb_src_d = PTR_W'(i);
                        end
                    end
                end
                new_state_d = (msg == MSG_READ_MISS) ? (others_inv ? MESI_E : MESI_S) : emit.nxt;
                miss_d      = (msg == MSG_READ_MISS) || (msg == MSG_WRITE_MISS);
                bus_valid_d = (msg != MSG_NONE);
                bus_msg_d   = msg;
                if (wb_any) begin
                    wb_req_d = 1'b1;
                    fsm_d    = FSM_WB;
                end else if (miss_d) begin
                    mem_req_d = 1'b1;
                    fsm_d     = FSM_MEM;
                end else begin
                    fsm_d = FSM_UPDATE;
                end
            end

            FSM_WB: begin
                if (mem_ack) begin
                    wb_req_d = 1'b0;
                    if (miss) begin
                        mem_req_d = 1'b1;
                        fsm_d     = FSM_MEM;
                    end else begin
                        fsm_d = FSM_UPDATE;
                    end
                end
            end

            FSM_MEM: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    fsm_d     = FSM_UPDATE;
                end
            end

            FSM_UPDATE: begin
                for (int i = 0; i < int'(NPROC); i++) begin
                    if (PTR_W'(i) == idx) states_d[2*i +: 2] = new_state;
                end
                done_d = 1'b1;
                fsm_d  = FSM_IDLE;
            end

            default: fsm_d = FSM_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mesi_bus_ctrl.sv
// tb_mesi_bus_ctrl: directed self-checking bench for mesi_bus_ctrl (NPROC = 3).
module tb_mesi_bus_ctrl;

    localparam int unsigned NPROC = 3;
    localparam int unsigned PTR_W = 2;

    logic             clock = 1'b0;
    logic             reset;
    logic [NPROC-1:0] req;
    logic [NPROC-1:0] op;
    logic [NPROC-1:0] grant;
    logic             done;
    logic             bus_valid;
    logic [1:0]       bus_msg;
    logic             wb_req;
    logic [PTR_W-1:0] wb_src;
    logic             mem_req;
    logic             mem_ack;
    logic [5:0]       state_out;

    int n_checks = 0;
    int n_errors = 0;

    mesi_bus_ctrl #(.NPROC(NPROC), .PTR_W(PTR_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .op        (op),
        .grant     (grant),
        .done      (done),
        .bus_valid (bus_valid),
        .bus_msg   (bus_msg),
        .wb_req    (wb_req),
        .wb_src    (wb_src),
        .mem_req   (mem_req),
        .mem_ack   (mem_ack),
        .state_out (state_out)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one request, answer memory after ack_wait cycles, check the whole transaction
    task automatic run_txn(input string tag, input logic [2:0] rq, input logic [2:0] o,
                           input int ack_wait, input logic [2:0] exp_grant,
                           input logic [1:0] exp_msg, input int exp_lat,
                           input logic exp_wb, input logic [1:0] exp_src,
                           input logic exp_mem, input logic [5:0] exp_state);
        int w, cyc, bv_cnt, wb_cnt, mem_cnt;
        logic [1:0] msg_seen, src_seen;
        logic got_done;
        req = rq;
        op  = o;
        w   = 0;
        while (grant == '0 && w < 10) begin
            @(negedge clock);
            w++;
        end
        check_eq({tag, " grant"}, 32'(grant), 32'(exp_grant));
        cyc = 0; bv_cnt = 0; wb_cnt = 0; mem_cnt = 0;
        msg_seen = 2'd0; src_seen = 2'd0; got_done = 1'b0;
        while (!got_done && cyc < 60) begin
            @(negedge clock);
            cyc++;
            mem_ack = 1'b0;
            if (bus_valid) begin
                bv_cnt++;
                msg_seen = bus_msg;
            end
            if (wb_req) begin
                wb_cnt++;
                src_seen = wb_src;
                if (wb_cnt == ack_wait) mem_ack = 1'b1;
            end else if (mem_req) begin
                mem_cnt++;
                if (mem_cnt == ack_wait) mem_ack = 1'b1;
            end
            if (done) got_done = 1'b1;
        end
        check_eq({tag, " done seen"}, 32'(got_done), 32'd1);
        check_eq({tag, " latency"}, 32'(cyc), 32'(exp_lat));
        check_eq({tag, " bus strobes"}, 32'(bv_cnt), (exp_msg != 2'd0) ? 32'd1 : 32'd0);
        if (exp_msg != 2'd0) check_eq({tag, " bus_msg"}, 32'(msg_seen), 32'(exp_msg));
        check_eq({tag, " wb seen"}, 32'(wb_cnt > 0), 32'(exp_wb));
        if (exp_wb) begin
            check_eq({tag, " wb_src"}, 32'(src_seen), 32'(exp_src));
            check_eq({tag, " wb cycles"}, 32'(wb_cnt), 32'(ack_wait));
        end
        check_eq({tag, " mem seen"}, 32'(mem_cnt > 0), 32'(exp_mem));
        check_eq({tag, " state_out"}, 32'(state_out), 32'(exp_state));
        req = req & ~grant;
        mem_ack = 1'b0;
        @(negedge clock);
        check_eq({tag, " done pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [2:0] exp_seq [4];
        int w, cyc;
        exp_seq = '{3'b100, 3'b001, 3'b010, 3'b100};

        reset = 1'b1; req = '0; op = '0; mem_ack = 1'b0;
        @(negedge clock); @(negedge clock);
        check_eq("reset grant", 32'(grant), 32'd0);
        check_eq("reset state_out", 32'(state_out), 32'd0);
        check_eq("reset outputs", 32'({done, bus_valid, wb_req, mem_req, bus_msg, wb_src}), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Read misses, invalidate, dirty writeback
        run_txn("c0 read miss",  3'b001, 3'b000, 1, 3'b001, 2'd1, 3, 1'b0, 2'd0, 1'b1, 6'h02);
        run_txn("c1 read miss",  3'b010, 3'b000, 1, 3'b010, 2'd1, 3, 1'b0, 2'd0, 1'b1, 6'h05);
        run_txn("c0 write S",    3'b001, 3'b001, 1, 3'b001, 2'd3, 2, 1'b0, 2'd0, 1'b0, 6'h03);
        run_txn("c2 read wb",    3'b100, 3'b000, 3, 3'b100, 2'd1, 8, 1'b1, 2'd0, 1'b1, 6'h11);
        run_txn("c1 read share", 3'b010, 3'b000, 1, 3'b010, 2'd1, 3, 1'b0, 2'd0, 1'b1, 6'h15);

        // All three request continuously, all hit: strict rotation starting after cache 1
        req = 3'b111; op = 3'b000;
        for (int k = 0; k < 4; k++) begin
            w = 0;
            while (grant == '0 && w < 10) begin
                @(negedge clock);
                w++;
            end
            check_eq("rr grant", 32'(grant), 32'(exp_seq[k]));
            cyc = 0;
            while (!done && cyc < 20) begin
                @(negedge clock);
                cyc++;
                check_eq("rr no bus", 32'(bus_valid), 32'd0);
            end
            check_eq("rr latency", 32'(cyc), 32'd2);
            if (k == 3) req = '0;
            @(negedge clock);
        end
        check_eq("rr state_out", 32'(state_out), 32'h15);
        check_eq("rr idle grant", 32'(grant), 32'd0);

        run_txn("c0 write inv",  3'b001, 3'b001, 1, 3'b001, 2'd3, 2, 1'b0, 2'd0, 1'b0, 6'h03);

        // Abort a transaction in writeback with an asynchronous reset
        req = 3'b010; op = 3'b000;
        w = 0;
        while (!wb_req && w < 20) begin
            @(negedge clock);
            w++;
        end
        check_eq("abort wb reached", 32'(wb_req), 32'd1);
        reset = 1'b1;
        #1;
        check_eq("abort grant", 32'(grant), 32'd0);
        check_eq("abort state_out", 32'(state_out), 32'd0);
        check_eq("abort outputs", 32'({done, bus_valid, wb_req, mem_req, bus_msg, wb_src}), 32'd0);
        req = '0;
        @(negedge clock); @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Pointer reset: cache 1 beats cache 2; then cache 2 follows immediately
        run_txn("post reset c1", 3'b110, 3'b000, 1, 3'b010, 2'd1, 3, 1'b0, 2'd0, 1'b1, 6'h08);
        run_txn("post reset c2", 3'b100, 3'b000, 1, 3'b100, 2'd1, 3, 1'b0, 2'd0, 1'b1, 6'h14);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
